// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: credit-limited requests to a variable-latency imem,
// a small {pc, instr} queue feeding IF/ID, and redirects that discard stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        validF
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          SW  = CW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]   req_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    // In-flight PC queue; its occupancy is always outstanding + drop.
    logic [31:0]   ifq_mem [DEPTH];
    logic [PW-1:0] ifq_wr;
    logic [PW-1:0] ifq_rd;

    fetch_entry_t  fq_mem [DEPTH];
    logic [PW-1:0] fq_wr;
    logic [PW-1:0] fq_rd;
    logic [CW-1:0] fq_count;

    logic          issue;
    logic          resp_ok;
    logic          fq_push;
    logic          fq_pop;
    logic          has_head;
    logic [SW-1:0] committed;

    // Every issued request owns a queue slot until its response is consumed or dropped.
    assign committed      = SW'(outstanding) + SW'(drop) + SW'(fq_count);
    assign imem_req_valid = !rst && !redirect && (committed < SW'(DEPTH));
    assign imem_req_addr  = req_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is a protocol error and is ignored.
    assign resp_ok  = imem_resp_valid && (outstanding != '0 || drop != '0);
    assign fq_push  = resp_ok && (drop == '0) && !redirect;
    assign has_head = (fq_count != '0);
    assign fq_pop   = has_head && !stall && !redirect;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect) begin
            req_pc      <= redirect_pc & 32'hFFFF_FFFC;
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(resp_ok);
        end else begin
            if (issue) begin
                req_pc <= req_pc + 32'd4;
            end
            if (resp_ok && drop != '0) begin
                drop <= drop - CW'(1);
            end
            outstanding <= outstanding + CW'(issue) - CW'(resp_ok && drop == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifq_wr <= '0;
            ifq_rd <= '0;
        end else begin
            if (issue) begin
                ifq_wr <= ifq_wr + PW'(1);
            end
            if (resp_ok) begin
                ifq_rd <= ifq_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else if (redirect) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_count <= '0;
        end else begin
            if (fq_push) begin
                fq_wr <= fq_wr + PW'(1);
            end
            if (fq_pop) begin
                fq_rd <= fq_rd + PW'(1);
            end
            fq_count <= fq_count + CW'(fq_push) - CW'(fq_pop);
        end
    end

    // NOTE: queue storage is not reset; occupancy counters and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            ifq_mem[ifq_wr] <= req_pc;
        end
        if (fq_push) begin
            fq_mem[fq_wr] <= '{pc: ifq_mem[ifq_rd], instr: imem_resp_data};
        end
    end

    // NOTE: defaults are assigned first so no path through the block leaves an output unassigned (no latch).
    always_comb begin
        pcF    = '0;
        instrF = NOP;
        if (has_head) begin
            pcF    = fq_mem[fq_rd].pc;
            instrF = fq_mem[fq_rd].instr;
        end
    end

    assign validF = has_head;

    a_resp_protocol: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding != '0 || drop != '0));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        committed <= SW'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, in-order variable-latency
// memory, directed scenarios followed by randomized traffic with a mid-stream async reset.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        stall, redirect, validF;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, pcF, instrF;

    logic        w_req_valid, w_validF;
    logic        w_resp_valid = 1'b0;
    logic        w_pending = 1'b0;
    logic [31:0] w_req_addr, w_pcF, w_instrF;
    logic [31:0] w_resp_data = 32'h0;
    logic [31:0] w_log[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .pcF(pcF), .instrF(instrF), .validF(validF)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .pcF(w_pcF), .instrF(w_instrF), .validF(w_validF)
    );

    // Latency-1 memory for the wrap-around instance; logs its first accepted addresses.
    always @(negedge clk) begin
        if (rst) begin
            w_resp_valid = 1'b0;
            w_pending    = 1'b0;
        end else begin
            w_resp_valid = w_pending;
            w_resp_data  = $urandom;
            #1;
            w_pending = w_req_valid;
            if (w_req_valid && w_log.size() < 3) w_log.push_back(w_req_addr);
        end
    end

    typedef struct { logic [31:0] pc; bit stale; }          flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { int due; logic [31:0] data; }          mem_t;

    flight_t     m_flight[$];
    entry_t      m_fq[$];
    mem_t        mem_q[$];
    logic [31:0] m_req_pc;
    logic [31:0] addr_log[$];
    logic [31:0] pop_log[$];
    int cyc, last_due, lat_min, lat_max, first_valid_cyc;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_req_pc = 32'h0;
        m_flight.delete();
        m_fq.delete();
        mem_q.delete();
        last_due        = -1;
        cyc             = 0;
        first_valid_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag, input logic [31:0] rpc);
        check({tag, "_req_valid"}, imem_req_valid, 32'h0);
        check({tag, "_req_addr"},  imem_req_addr,  rpc);
        check({tag, "_validF"},    validF,         32'h0);
        check({tag, "_pcF"},       pcF,            32'h0);
        check({tag, "_instrF"},    instrF,         NOP);
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the model, advance the model.
    task automatic step(input bit rdy, input bit stl, input bit redir, input logic [31:0] rpc);
        bit          rvalid, exp_rv, exp_vf, issue;
        logic [31:0] rdata;
        flight_t     f;
        entry_t      e;
        mem_t        m;
        int          due;

        rvalid = (mem_q.size() != 0) && (mem_q[0].due == cyc);
        rdata  = rvalid ? mem_q[0].data : $urandom;
        imem_req_ready  = rdy;
        stall           = stl;
        redirect        = redir;
        redirect_pc     = rpc;
        imem_resp_valid = rvalid;
        imem_resp_data  = rdata;
        #1;

        exp_rv = !redir && (m_flight.size() + m_fq.size() < DEPTH);
        exp_vf = (m_fq.size() != 0);
        check("req_valid", imem_req_valid, exp_rv);
        check("req_addr",  imem_req_addr,  m_req_pc);
        check("validF",    validF,         exp_vf);
        check("pcF",       pcF,            exp_vf ? m_fq[0].pc : 32'h0);
        check("instrF",    instrF,         exp_vf ? m_fq[0].instr : NOP);

        if (imem_req_valid && rdy) addr_log.push_back(imem_req_addr);
        if (validF && !stl && !redir) pop_log.push_back(pcF);
        if (validF && first_valid_cyc < 0) first_valid_cyc = cyc;

        issue = exp_rv && rdy;
        if (rvalid) begin
            void'(mem_q.pop_front());
            f = m_flight.pop_front();
            if (!f.stale && !redir) begin
                e.pc    = f.pc;
                e.instr = rdata;
                m_fq.push_back(e);
            end
        end
        if (redir) begin
            m_fq.delete();
            foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            m_req_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_vf && !stl) void'(m_fq.pop_front());
            if (issue) begin
                f.pc    = m_req_pc;
                f.stale = 1'b0;
                m_flight.push_back(f);
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.due    = due;
                m.data   = $urandom;
                mem_q.push_back(m);
                m_req_pc = m_req_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit          found;
        logic [31:0] c_head;

        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        lat_min = 1;
        lat_max = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset", 32'h0);
        rst = 1'b0;
        model_reset();

        // Streaming, latency 1, no stall.
        addr_log.delete();
        pop_log.delete();
        repeat (12) step(1, 0, 0, 32'h0);
        check("A_first_validF_cycle", first_valid_cyc, 32'd2);
        check("A_addr0", at(addr_log, 0), 32'h0);
        check("A_addr1", at(addr_log, 1), 32'h4);
        check("A_addr2", at(addr_log, 2), 32'h8);
        check("A_pop0",  at(pop_log, 0),  32'h0);
        check("A_pop1",  at(pop_log, 1),  32'h4);
        check("A_pop2",  at(pop_log, 2),  32'h8);

        // Memory not ready: queue drains to the bubble.
        repeat (5) step(0, 0, 0, 32'h0);
        check("B_validF", validF, 32'h0);
        check("B_pcF",    pcF,    32'h0);
        check("B_instrF", instrF, NOP);

        // Decode stall fills the queue, then releases in order.
        repeat (4) step(1, 1, 0, 32'h0);
        check("C_req_valid_blocked", imem_req_valid, 32'h0);
        check("C_validF_held",       validF,         32'h1);
        check("C_model_buffered",    m_fq.size(),    DEPTH);
        c_head = m_fq[0].pc;
        pop_log.delete();
        repeat (6) step(1, 0, 0, 32'h0);
        check("C_pop0", at(pop_log, 0), c_head);
        check("C_pop1", at(pop_log, 1), c_head + 32'd4);
        check("C_pop2", at(pop_log, 2), c_head + 32'd8);

        // Latency 3, redirect with two requests in flight.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_flight.size() == 2) found = 1'b1;
            else step(1, 0, 0, 32'h0);
        end
        check("D_two_in_flight", found, 32'h1);
        addr_log.delete();
        pop_log.delete();
        step(1, 0, 1, 32'h0000_0100);
        repeat (12) step(1, 0, 0, 32'h0);
        check("D_first_req", at(addr_log, 0), 32'h0000_0100);
        check("D_first_pop", at(pop_log, 0),  32'h0000_0100);

        // Redirect colliding with a response and a stall; misaligned target.
        lat_min = 2;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() != 0 && mem_q[0].due == cyc) found = 1'b1;
            else step(1, 0, 0, 32'h0);
        end
        check("E_resp_due", found, 32'h1);
        addr_log.delete();
        pop_log.delete();
        step(1, 1, 1, 32'h0000_0203);
        check("E_validF_cleared", validF, 32'h0);
        repeat (10) step(1, 0, 0, 32'h0);
        check("E_first_req", at(addr_log, 0), 32'h0000_0200);
        check("E_first_pop", at(pop_log, 0),  32'h0000_0200);

        // Randomized traffic with an asynchronous reset in the middle.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #3 rst = 1'b1;
                #1;
                check_reset_outputs("async_rst", 32'h0);
                imem_resp_valid = 1'b0;
                redirect        = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0,
                 $urandom_range(15, 0) == 0, $urandom);
        end

        check("W_addr0", at(w_log, 0), 32'hFFFF_FFF8);
        check("W_addr1", at(w_log, 1), 32'hFFFF_FFFC);
        check("W_addr2", at(w_log, 2), 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
